alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 42 ++++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter:
// FSM state encoding, RV func3 opcodes and shift-amount sizing.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // 6-bit shift amount for 64-bit data, 5-bit for 32-bit data.
    function automatic int shamt_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational RV integer ALU: add/sub, shifts, signed/unsigned compare, logic ops.
// alt selects sub on func3=000 and sra on func3=101.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            func3,
    input  logic                  alt,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SHAMT_W = shamt_width(DATA_WIDTH);

    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] sra_result;

    assign shamt = in2[SHAMT_W-1:0];

    // Kept as its own signed assignment so the arithmetic shift is not
    // turned logical by sharing an expression with an unsigned operand.
    assign sra_result = $signed(in1) >>> shamt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        case (func3)
            F3_ADD:  result = alt ? (in1 - in2) : (in1 + in2);
            F3_SLL:  result = in1 << shamt;
            F3_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            F3_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (in1 < in2)};
            F3_XOR:  result = in1 ^ in2;
            F3_SRL:  result = alt ? sra_result : (in1 >> shamt);
            F3_OR:   result = in1 | in2;
            F3_AND:  result = in1 & in2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE grants and latches an operation, EXEC computes, RESP holds the result until consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_func3,
    input  logic                  req0_alt,
    input  logic [DATA_WIDTH-1:0] req0_in1,
    input  logic [DATA_WIDTH-1:0] req0_in2,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_func3,
    input  logic                  req1_alt,
    input  logic [DATA_WIDTH-1:0] req1_in1,
    input  logic [DATA_WIDTH-1:0] req1_in2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  busy,
    output logic [31:0]           op_count
);

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [2:0]            func3_q, func3_d;
    logic                  alt_q, alt_d;
    logic [DATA_WIDTH-1:0] in1_q, in1_d;
    logic [DATA_WIDTH-1:0] in2_q, in2_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q, rsp_zero_d;
    logic [31:0]           op_count_q, op_count_d;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  grant_id;
    logic                  accept;

    // With both valid the priority holder wins; otherwise whoever is valid wins.
    assign grant_id = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign accept   = (state_q == IDLE) && (req0_valid || req1_valid);

    alu_arbiter_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .func3  (func3_q),
        .alt    (alt_q),
        .in1    (in1_q),
        .in2    (in2_q),
        .result (alu_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = rst_n && accept && !grant_id;
        req1_ready = rst_n && accept && grant_id;
        rsp_valid  = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    always_comb begin
        prio_d       = prio_q;
        func3_d      = func3_q;
        alt_d        = alt_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        op_count_d   = op_count_q;

        if (accept) begin
            prio_d   = ~grant_id;
            rsp_id_d = grant_id;
            func3_d  = grant_id ? req1_func3 : req0_func3;
            alt_d    = grant_id ? req1_alt   : req0_alt;
            in1_d    = grant_id ? req1_in1   : req0_in1;
            in2_d    = grant_id ? req1_in2   : req0_in2;
        end

        if (state_q == EXEC) begin
            rsp_result_d = alu_result;
            rsp_zero_d   = (alu_result == '0);
        end

        if (rsp_valid && rsp_ready) begin
            op_count_d = op_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q       <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            prio_q       <= prio_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            op_count_q   <= op_count_d;
        end
    end

    // NOTE: latched operands are only read after an acceptance has written them, so they carry no reset.
    always_ff @(posedge clk) begin
        func3_q <= func3_d;
        alt_q   <= alt_d;
        in1_q   <= in1_d;
        in2_q   <= in2_d;
    end

    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign op_count   = op_count_q;

endmodule
